cdc_req_ack_responder: RTL and testbench
========================================

// Module: cdc_req_ack_responder
// PURPOSE
//  Destination-side responder of a 4-phase req/ack CDC handshake. Synchronises
//  a level request from a foreign clock domain and captures the accompanying
//  data bus. Presents the data on a local valid/ready interface and returns a
//  registered ack level to the source. Sits in the receiving domain of any
//  multi-bit or feedback-controlled cross-domain transfer.
// PARAMETERS
//  SYNC_STAGES  2  synchroniser depth on req_async; legal values >= 2
//  DATA_W       8  width of transferred data word
// PORTS
//  clk         in   1       local (destination) clock
//  rst         in   1       asynchronous, active-high reset
//  req_async   in   1       request level from source domain (4-phase)
//  data_async  in   DATA_W  source data, stable while req_async high
//  ack         out  1       acknowledge level to source; driven straight from a flop
//  out_valid   out  1       captured word available
//  out_data    out  DATA_W  captured word; stable while out_valid=1
//  out_ready   in   1       local consumer accepts word when out_valid & out_ready
//  out_pulse   out  1       single-cycle strobe on capture
//  proto_err   out  1       sticky: req dropped before word was accepted
//  err_clr     in   1       synchronous clear of proto_err
// BEHAVIOUR
//  - Reset (async assert, release on clk): sync chain=0, state IDLE, ack=0,
//    out_valid=0, out_data=0, out_pulse=0, proto_err=0.
//  - req_sync = final stage of SYNC_STAGES-flop chain on req_async.
//  - FSM states IDLE, HOLD, ACK:
//    IDLE: req_sync=1 -> out_data<=data_async, out_valid<=1, out_pulse<=1 for
//          one cycle, go HOLD. data_async sampled unsynchronised in that cycle only
//          (4-phase guarantees stability).
//    HOLD: out_valid=1, out_data frozen. out_ready=1 -> out_valid<=0, ack<=1,
//          go ACK. out_ready is ignored in every state other than HOLD.
//    ACK:  ack=1 until req_sync=0 -> ack<=0, go IDLE.
//  - Latency: req_async rise -> out_valid/out_pulse high after SYNC_STAGES+1 clks;
//    accept -> ack high next clk; req_async fall -> ack low after SYNC_STAGES+1 clks.
//  - Throughput: one word per full 4-phase round trip; no buffering beyond one word.
//  - req_sync=0 seen in HOLD: proto_err<=1. The captured word is kept and the
//    transfer completes normally. ACK then sees req low and returns to IDLE on the
//    next clk.
//  - Simultaneous proto_err set and err_clr: set wins.
//  - A req_async glitch shorter than one clk may be missed. It is captured only if
//    it reaches req_sync.
//  - Reset mid-transfer: ack drops asynchronously and any held word is discarded.
//    If req_async is still high after release, it is treated as a new request:
//    the current data is captured after SYNC_STAGES+1 clks.
//  - No combinational path from any input to any output.
// TESTING
//  1. Reset: rst=1 with random inputs -> ack, out_valid, out_pulse, proto_err,
//     out_data all 0.
//  2. Basic (SYNC_STAGES=2): data_async=8'hA5, req rises at clk 0, out_ready=1
//     -> out_valid and out_pulse at clk 3, out_data=8'hA5, ack=1 at clk 4.
//     Then req falls -> ack=0 three clks later; FSM back in IDLE.
//  3. Backpressure: out_ready=0 for 10 clks -> out_valid=1 and out_data=8'h3C held,
//     ack=0 throughout. out_ready=1 -> out_valid=0 and ack=1 on the next clk.
//  4. Protocol error: req drops in HOLD -> proto_err=1 and sticky; word still
//     delivered. err_clr=1 -> proto_err=0. err_clr coincident with a new error ->
//     proto_err stays 1.
//  5. Stream: 16 back-to-back transfers, random data, random out_ready -> delivered
//     sequence equals sent sequence; exactly 16 out_pulse strobes; no ack overlap.
//  6. Reset in ACK with req held high -> ack=0 immediately. After release, out_valid=1
//     at clk SYNC_STAGES+1 with the current data_async value.

Source files
------------

// File: rtl/cdc_req_ack_responder.sv
// Destination-side responder for a 4-phase req/ack CDC handshake: synchronises req,
// captures the source word once, hands it over on valid/ready and returns a registered ack.
module cdc_req_ack_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DATA_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_async,
  input  logic [DATA_W-1:0] data_async,
  output logic              ack,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              out_pulse,
  output logic              proto_err,
  input  logic              err_clr
);

  typedef enum logic [1:0] {StIdle, StHold, StAck} state_e;

  state_e              state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                req_sync;
  logic                ack_q, ack_d;
  logic                valid_q, valid_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                pulse_q, pulse_d;
  logic                err_q, err_d;

  assign req_sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      state_q <= StIdle;
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      pulse_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], req_async};
      state_q <= state_d;
      ack_q   <= ack_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      pulse_q <= pulse_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req_sync)  state_d = StHold;
      StHold:  if (out_ready) state_d = StAck;
      StAck:   if (!req_sync) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ack_d   = ack_q;
    valid_d = valid_q;
    data_d  = data_q;
    pulse_d = 1'b0;
    err_d   = err_clr ? 1'b0 : err_q;
    unique case (state_q)
      StIdle: begin
        // data_async is only stable while req is high, so it is sampled here and nowhere else.
        if (req_sync) begin
          data_d  = data_async;
          valid_d = 1'b1;
          pulse_d = 1'b1;
        end
      end
      StHold: begin
        // Early req drop is flagged but the held word is still delivered; set beats clear.
        if (!req_sync) err_d = 1'b1;
        if (out_ready) begin
          valid_d = 1'b0;
          ack_d   = 1'b1;
        end
      end
      StAck: begin
        if (!req_sync) ack_d = 1'b0;
      end
      default: begin
        ack_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  assign ack       = ack_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_pulse = pulse_q;
  assign proto_err = err_q;

endmodule

// File: tb/tb_cdc_req_ack_responder.sv
// Bench for cdc_req_ack_responder: directed handshakes with a scoreboard queue of sent
// words, popped by a monitor on every accepted output word.
module tb_cdc_req_ack_responder;

  localparam int unsigned SyncStages = 2;
  localparam int unsigned DataW      = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_async = 1'b0;
  logic [DataW-1:0] data_async = '0;
  logic             ack;
  logic             out_valid;
  logic [DataW-1:0] out_data;
  logic             out_ready = 1'b0;
  logic             out_pulse;
  logic             proto_err;
  logic             err_clr = 1'b0;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  int accept_cnt = 0;
  logic [DataW-1:0] sb[$];

  cdc_req_ack_responder #(
    .SYNC_STAGES(SyncStages),
    .DATA_W     (DataW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_async (req_async),
    .data_async(data_async),
    .ack       (ack),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .out_pulse (out_pulse),
    .proto_err (proto_err),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (out_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk(name, out_valid, 1'b1);
  endtask

  task automatic wait_ack(input logic lvl, input string name);
    int n = 0;
    while (ack !== lvl && n < 50) begin
      tick();
      n++;
    end
    chk(name, ack, lvl);
  endtask

  // Monitor: scoreboard pop on each accepted word, strobe count, ack/valid exclusivity.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_pulse) pulse_cnt++;
      chk("ack_valid_overlap", ack && out_valid, 1'b0);
      if (out_valid && out_ready) begin
        accept_cnt++;
        if (sb.size() == 0) chk("sb_unexpected_word", 1'b1, 1'b0);
        else chk("sb_data", out_data, sb.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int a0;
    logic [DataW-1:0] d;

    // 1. Reset with random inputs
    req_async  = 1'($urandom_range(0, 1));
    data_async = 8'($urandom);
    out_ready  = 1'($urandom_range(0, 1));
    err_clr    = 1'($urandom_range(0, 1));
    repeat (4) tick();
    chk("rst_ack", ack, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_pulse", out_pulse, 0);
    chk("rst_err", proto_err, 0);
    chk("rst_data", out_data, 0);
    req_async = 1'b0;
    err_clr   = 1'b0;
    out_ready = 1'b1;
    rst = 1'b0;
    repeat (4) tick();

    // 2. Basic transfer and latency
    data_async = 8'hA5;
    req_async  = 1'b1;
    sb.push_back(8'hA5);
    tick(); chk("basic_valid_c1", out_valid, 0);
    tick(); chk("basic_valid_c2", out_valid, 0);
    tick();
    chk("basic_valid_c3", out_valid, 1);
    chk("basic_pulse_c3", out_pulse, 1);
    chk("basic_data_c3", out_data, 8'hA5);
    chk("basic_ack_c3", ack, 0);
    tick();
    chk("basic_ack_c4", ack, 1);
    chk("basic_valid_c4", out_valid, 0);
    chk("basic_pulse_c4", out_pulse, 0);
    tick();
    req_async = 1'b0;
    tick(); chk("basic_ackfall_c1", ack, 1);
    tick(); chk("basic_ackfall_c2", ack, 1);
    tick(); chk("basic_ackfall_c3", ack, 0);
    repeat (2) tick();

    // 3. Backpressure
    out_ready  = 1'b0;
    data_async = 8'h3C;
    req_async  = 1'b1;
    sb.push_back(8'h3C);
    wait_valid("bp_valid");
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_data", out_data, 8'h3C);
      chk("bp_hold_ack", ack, 0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_ack", ack, 1);
    req_async  = 1'b0;
    data_async = 8'hFF;
    wait_ack(1'b0, "bp_ack_low");
    repeat (2) tick();

    // 4. Protocol error: req drops in HOLD
    out_ready  = 1'b0;
    data_async = 8'h5A;
    req_async  = 1'b1;
    sb.push_back(8'h5A);
    wait_valid("perr_valid");
    req_async = 1'b0;
    tick(); tick();
    chk("perr_not_yet", proto_err, 0);
    tick();
    chk("perr_set", proto_err, 1);
    chk("perr_word_kept", out_data, 8'h5A);
    chk("perr_valid_kept", out_valid, 1);
    out_ready = 1'b1;
    tick();
    chk("perr_ack_hi", ack, 1);
    chk("perr_valid_lo", out_valid, 0);
    tick();
    chk("perr_ack_lo", ack, 0);
    chk("perr_sticky", proto_err, 1);
    tick();
    chk("perr_sticky2", proto_err, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("perr_cleared", proto_err, 0);
    // Clear coincident with a new error: set wins
    out_ready  = 1'b0;
    data_async = 8'h77;
    req_async  = 1'b1;
    sb.push_back(8'h77);
    wait_valid("perr2_valid");
    req_async = 1'b0;
    tick(); tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("perr_set_wins", proto_err, 1);
    out_ready = 1'b1;
    wait_ack(1'b1, "perr2_ack_hi");
    wait_ack(1'b0, "perr2_ack_lo");
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("perr2_cleared", proto_err, 0);
    repeat (2) tick();

    // 5. Stream of 16 words with random out_ready
    p0 = pulse_cnt;
    a0 = accept_cnt;
    for (int w = 0; w < 16; w++) begin
      int n;
      d = 8'($urandom);
      data_async = d;
      req_async  = 1'b1;
      sb.push_back(d);
      n = 0;
      while (ack !== 1'b1 && n < 200) begin
        out_ready = 1'($urandom_range(0, 1));
        tick();
        n++;
      end
      chk("stream_ack_hi", ack, 1);
      req_async  = 1'b0;
      out_ready  = 1'($urandom_range(0, 1));
      data_async = 8'($urandom);
      wait_ack(1'b0, "stream_ack_lo");
    end
    tick();
    chk("stream_pulses", 32'(pulse_cnt - p0), 16);
    chk("stream_accepts", 32'(accept_cnt - a0), 16);
    chk("stream_no_err", proto_err, 0);

    // 6. Reset while in ACK with req still high
    out_ready  = 1'b1;
    data_async = 8'h11;
    req_async  = 1'b1;
    sb.push_back(8'h11);
    wait_ack(1'b1, "rstack_ack_hi");
    tick();
    data_async = 8'hC3;
    rst = 1'b1;
    #1;
    chk("rstack_ack_async", ack, 0);
    chk("rstack_valid", out_valid, 0);
    sb.push_back(8'hC3);
    tick(); tick();
    rst = 1'b0;
    tick(); chk("rstack_new_c1", out_valid, 0);
    tick(); chk("rstack_new_c2", out_valid, 0);
    tick();
    chk("rstack_new_c3", out_valid, 1);
    chk("rstack_new_data", out_data, 8'hC3);
    chk("rstack_new_pulse", out_pulse, 1);
    wait_ack(1'b1, "rstack_new_ack_hi");
    req_async = 1'b0;
    wait_ack(1'b0, "rstack_new_ack_lo");
    repeat (3) tick();
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
